// File: rtl/spinner_pkg.sv
// Shared types and helpers for the spinner quadrature receive path.
// Gray sequence, step classification and the prev->cur decoder.
package spinner_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN,
    STEP_ERR
  } step_e;

  // Counting-up order of the AB pair, A in bit 1
  localparam quad_t GRAY_0 = 2'b00;
  localparam quad_t GRAY_1 = 2'b01;
  localparam quad_t GRAY_2 = 2'b11;
  localparam quad_t GRAY_3 = 2'b10;

  function automatic logic [1:0] gray_idx(quad_t q);
    logic [1:0] r;
    r = 2'd0;
    unique case (q)
      GRAY_0: r = 2'd0;
      GRAY_1: r = 2'd1;
      GRAY_2: r = 2'd2;
      GRAY_3: r = 2'd3;
    endcase
    return r;
  endfunction

  function automatic step_e quad_decode(quad_t prev, quad_t cur);
    logic [1:0] d;
    step_e      r;
    d = gray_idx(cur) - gray_idx(prev);
    r = STEP_NONE;
    unique case (1'b1)
      (d == 2'd0): r = STEP_NONE;
      (d == 2'd1): r = STEP_UP;
      (d == 2'd3): r = STEP_DN;
      (d == 2'd2): r = STEP_ERR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spinner_quad_decoder_filter.sv
// quad_input_filter: holds the AB pair until a new value persists
// FILT_LEN cycles. Only built with SPINNER_FILTER_EN defined.
`ifdef SPINNER_FILTER_EN
module quad_input_filter
  import spinner_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic  clk_12m,
  input  logic  reset,
  input  quad_t d_ab,
  output quad_t q_ab
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] run;
  quad_t         cand;

  // run = length of the current streak of d_ab including this sample
  always_comb begin
    run = CW'(1);
    if (d_ab == cand) run = cnt + CW'(1);
  end

  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      q_ab <= d_ab;
      cand <= d_ab;
      cnt  <= '0;
    end else if (d_ab == q_ab) begin
      cnt  <= '0;
    end else if (run >= CW'(FILT_LEN)) begin
      q_ab <= d_ab;
      cnt  <= '0;
    end else begin
      cand <= d_ab;
      cnt  <= run;
    end
  end

endmodule
`endif

// File: rtl/spinner_quad_decoder.sv
// Spinner AB quadrature receiver: sync, optional glitch filter
// (SPINNER_FILTER_EN), 4x decode, wrapping position, saturating delta.
module spinner_quad_decoder
  import spinner_pkg::*;
#(
  parameter int CNT_W   = 12,
  parameter int DELTA_W = 9
`ifdef SPINNER_FILTER_EN
  ,
  parameter int FILT_LEN = 4
`endif
) (
  input  logic               clk_12m,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               latch,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   position,
  output logic [DELTA_W-1:0] delta,
  output logic               delta_vld,
  output logic               step,
  output logic               dir,
  output logic               err
);

  localparam logic [CNT_W-1:0] POS_ONE = CNT_W'(1);
  localparam logic [DELTA_W-1:0] ACC_ONE = DELTA_W'(1);
  localparam logic [DELTA_W-1:0] ACC_MAX = {1'b0, {(DELTA_W-1){1'b1}}};
  localparam logic [DELTA_W-1:0] ACC_MIN = {1'b1, {(DELTA_W-1){1'b0}}};

  quad_t              sync1;
  quad_t              sync2;
  quad_t              q_ab;
  quad_t              prev_ab;
  step_e              ev;
  logic               up;
  logic               dn;
  logic [DELTA_W-1:0] acc;
  logic [DELTA_W-1:0] acc_nxt;

  // Pins are asynchronous; no reset so prev_ab can load a live value
  always_ff @(posedge clk_12m) begin
    sync1 <= {enc_a, enc_b};
    sync2 <= sync1;
  end

`ifdef SPINNER_FILTER_EN
  quad_input_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk_12m (clk_12m),
    .reset   (reset),
    .d_ab    (sync2),
    .q_ab    (q_ab)
  );
`else
  assign q_ab = sync2;
`endif

  assign ev = quad_decode(prev_ab, q_ab);
  assign up = (ev == STEP_UP);
  assign dn = (ev == STEP_DN);

  always_comb begin
    acc_nxt = acc;
    if (up && acc != ACC_MAX) acc_nxt = acc + ACC_ONE;
    else if (dn && acc != ACC_MIN) acc_nxt = acc - ACC_ONE;
  end

  always_ff @(posedge clk_12m) begin
    if (!reset) begin
      prev_ab   <= q_ab;
      position  <= '0;
      acc       <= '0;
      delta     <= '0;
      delta_vld <= 1'b0;
      step      <= 1'b0;
      dir       <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev_ab   <= q_ab;
      step      <= up | dn;
      delta_vld <= latch;
      if (up) position <= position + POS_ONE;
      else if (dn) position <= position - POS_ONE;
      if (up | dn) dir <= up;
      // a step landing on the latch edge goes into this delta
      if (latch) begin
        delta <= acc_nxt;
        acc   <= '0;
      end else begin
        acc   <= acc_nxt;
      end
      if (ev == STEP_ERR) err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spinner_quad_decoder.sv
// Scoreboard bench for spinner_quad_decoder; handles both builds
// (SPINNER_FILTER_EN defined or not).
module tb_spinner_quad_decoder;

  localparam int CNT_W   = 12;
  localparam int DELTA_W = 9;
  localparam int HOLD    = 8;
`ifdef SPINNER_FILTER_EN
  localparam int FILT_LEN = 4;
  localparam int PRE      = 2 + FILT_LEN;
`else
  localparam int PRE      = 2;
`endif

  logic               clk_12m = 1'b0;
  logic               reset   = 1'b0;
  logic               enc_a   = 1'b1;
  logic               enc_b   = 1'b1;
  logic               latch   = 1'b0;
  logic               err_clr = 1'b0;
  logic [CNT_W-1:0]   position;
  logic [DELTA_W-1:0] delta;
  logic               delta_vld;
  logic               step;
  logic               dir;
  logic               err;

  always #5 clk_12m = ~clk_12m;

  spinner_quad_decoder #(
    .CNT_W   (CNT_W),
    .DELTA_W (DELTA_W)
  ) dut (
    .clk_12m   (clk_12m),
    .reset     (reset),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .latch     (latch),
    .err_clr   (err_clr),
    .position  (position),
    .delta     (delta),
    .delta_vld (delta_vld),
    .step      (step),
    .dir       (dir),
    .err       (err)
  );

  typedef struct packed {
    logic [CNT_W-1:0] pos;
    logic             dir;
  } sexp_t;

  sexp_t step_q[$];
  int    delta_q[$];

  int n_chk     = 0;
  int n_fail    = 0;
  int obs_steps = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gidx(logic [1:0] q);
    case (q)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // 0 none, 1 up, 3 down, 2 illegal
  function automatic int mdecode(logic [1:0] p, logic [1:0] c);
    return (gidx(c) - gidx(p) + 4) % 4;
  endfunction

  function automatic logic [1:0] nxt_up(logic [1:0] q);
    case (q)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nxt_dn(logic [1:0] q);
    case (q)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  logic [1:0]       m_s1   = 2'b11;
  logic [1:0]       m_s2   = 2'b11;
  logic [1:0]       m_prev = 2'b11;
  logic [1:0]       m_q    = 2'b11;
  logic [1:0]       m_last = 2'b11;
  int               m_run  = 0;
  logic [CNT_W-1:0] m_pos  = '0;
  int               m_acc  = 0;
  logic             m_err  = 1'b0;
  logic             m_dir  = 1'b0;

  task automatic model_edge();
    logic [1:0] qab;
    logic [1:0] s2_old;
    int         ev;
    s2_old = m_s2;
`ifdef SPINNER_FILTER_EN
    qab = m_q;
`else
    qab = m_s2;
`endif
    ev = mdecode(m_prev, qab);
    m_prev = qab;
    if (!reset) begin
      m_pos  = '0;
      m_acc  = 0;
      m_err  = 1'b0;
      m_dir  = 1'b0;
      m_q    = s2_old;
      m_last = s2_old;
      m_run  = 0;
    end else begin
      if (ev == 1) begin
        m_pos++;
        m_dir = 1'b1;
        if (m_acc < 255) m_acc++;
        step_q.push_back('{m_pos, 1'b1});
      end else if (ev == 3) begin
        m_pos--;
        m_dir = 1'b0;
        if (m_acc > -256) m_acc--;
        step_q.push_back('{m_pos, 1'b0});
      end
      if (latch) begin
        delta_q.push_back(m_acc);
        m_acc = 0;
      end
      if (ev == 2) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
`ifdef SPINNER_FILTER_EN
      if (s2_old == m_q) m_run = 0;
      else begin
        if (s2_old == m_last) m_run++;
        else m_run = 1;
        if (m_run >= FILT_LEN) begin
          m_q   = s2_old;
          m_run = 0;
        end
      end
      m_last = s2_old;
`endif
    end
    m_s2 = m_s1;
    m_s1 = {enc_a, enc_b};
  endtask

  task automatic monitor();
    sexp_t e;
    int    d;
    if (step === 1'b1) begin
      obs_steps++;
      if (step_q.size() == 0) chk("step_unexp", {31'd0, step}, 32'd0);
      else begin
        e = step_q.pop_front();
        chk("sb_pos", 32'(position), 32'(e.pos));
        chk("sb_dir", {31'd0, dir}, {31'd0, e.dir});
      end
    end
    if (delta_vld === 1'b1) begin
      if (delta_q.size() == 0) chk("vld_unexp", {31'd0, delta_vld}, 32'd0);
      else begin
        d = delta_q.pop_front();
        chk("sb_delta", 32'($signed(delta)), 32'(d));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_12m);
    model_edge();
    #1;
    monitor();
  endtask

  task automatic hold(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ab(logic [1:0] ab, int n);
    {enc_a, enc_b} = ab;
    hold(n);
  endtask

  task automatic steps_up(int n);
    for (int i = 0; i < n; i++) set_ab(nxt_up({enc_a, enc_b}), HOLD);
  endtask

  task automatic do_latch();
    latch = 1'b1;
    tick();
    latch = 1'b0;
  endtask

  int               n0;
  logic [CNT_W-1:0] p0;

  initial begin
    reset = 1'b0;
    hold(4);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_delta", 32'(delta), 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_vld", {31'd0, delta_vld}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    reset = 1'b1;
    hold(10);
    chk("t1_pos", 32'(position), 32'd0);
    chk("t1_steps", 32'(obs_steps), 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);

    n0 = obs_steps;
    for (int i = 0; i < 4; i++) set_ab(nxt_dn({enc_a, enc_b}), HOLD);
    chk("t2_steps", 32'(obs_steps - n0), 32'd4);
    chk("t2_dir", {31'd0, dir}, 32'd0);
    chk("t2_pos", 32'(position), 32'hFFC);

    do_latch();
    chk("t3_dm4", 32'($signed(delta)), 32'hFFFF_FFFC);
    steps_up(3);
    chk("t3_pos_fff", 32'(position), 32'hFFF);
    do_latch();
    steps_up(1);
    chk("t3_wrap", 32'(position), 32'h000);
    do_latch();
    chk("t3_vld", {31'd0, delta_vld}, 32'd1);
    chk("t3_delta", 32'($signed(delta)), 32'd1);
    tick();
    chk("t3_vld_pulse", {31'd0, delta_vld}, 32'd0);

    steps_up(300);
    do_latch();
    chk("t4_sat", 32'($signed(delta)), 32'd255);
    hold(4);
    do_latch();
    chk("t4_zero", 32'($signed(delta)), 32'd0);
    chk("t4_vld", {31'd0, delta_vld}, 32'd1);

    while ({enc_a, enc_b} != 2'b00) steps_up(1);
    p0 = m_pos;
    set_ab(2'b11, HOLD);
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_pos", 32'(position), 32'(p0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_clr", {31'd0, err}, 32'd0);
    {enc_a, enc_b} = 2'b00;
    hold(PRE);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_err_wins", {31'd0, err}, {31'd0, m_err});
    chk("t5_err_set", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_clr2", {31'd0, err}, 32'd0);
    hold(HOLD);

`ifdef SPINNER_FILTER_EN
    n0 = obs_steps;
    enc_a = ~enc_a;
    hold(2);
    enc_a = ~enc_a;
    hold(12);
    chk("t6_glitch_steps", 32'(obs_steps - n0), 32'd0);
    chk("t6_glitch_err", {31'd0, err}, 32'd0);
    enc_a = ~enc_a;
    hold(6);
    hold(10);
    chk("t6_steps", 32'(obs_steps - n0), 32'd1);
    chk("t6_err", {31'd0, err}, 32'd0);
`endif

    do_latch();
    hold(2);
    {enc_a, enc_b} = nxt_up({enc_a, enc_b});
    hold(PRE);
    latch = 1'b1;
    tick();
    latch = 1'b0;
    chk("t7_step", {31'd0, step}, 32'd1);
    chk("t7_vld", {31'd0, delta_vld}, 32'd1);
    chk("t7_delta", 32'($signed(delta)), 32'd1);
    hold(HOLD);
    do_latch();
    chk("t7_next", 32'($signed(delta)), 32'd0);

    steps_up(2);
    {enc_a, enc_b} = nxt_up({enc_a, enc_b});
    tick();
    reset = 1'b0;
    hold(3);
    reset = 1'b1;
    n0 = obs_steps;
    hold(HOLD);
    chk("t8_pos", 32'(position), 32'd0);
    chk("t8_steps", 32'(obs_steps - n0), 32'd0);
    steps_up(1);
    chk("t8_resume", 32'(position), 32'd1);
    chk("t8_dir", {31'd0, dir}, 32'd1);

    chk("sb_step_left", 32'(step_q.size()), 32'd0);
    chk("sb_delta_left", 32'(delta_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
